rs_codeword_serializer: RTL
===========================

RS_CODEWORD_SERIALIZER -- requirements
Module: rs_codeword_serializer

Interface
REQ-001 SHALL have parameter MSG_LEN, default 64, the number of message bytes per codeword (fixed to match the encoder).
REQ-002 SHALL have parameter PAR_LEN, default 4, the number of parity bytes per codeword.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port msg_in, input, 8 bits x MSG_LEN: parallel message bytes, sampled on msg_valid.
REQ-006 SHALL have port msg_valid, input, 1 bit: a message is present this cycle.
REQ-007 SHALL have port msg_ready, output, 1 bit: the block will accept msg_in this cycle.
REQ-008 SHALL have port parity_in, input, 8 bits x PAR_LEN: parity bytes from the encoder.
REQ-009 SHALL have port parity_valid, input, 1 bit: parity_in is valid this cycle (one cycle after the message).
REQ-010 SHALL have port m_data, output, 8 bits: serial codeword byte.
REQ-011 SHALL have port m_valid, output, 1 bit: m_data is valid.
REQ-012 SHALL have port m_ready, input, 1 bit: downstream accepts m_data.
REQ-013 SHALL have port m_last, output, 1 bit: the current byte is the final codeword byte.
REQ-014 SHALL have port drop_cnt, output, 16 bits: count of dropped messages.

Function
REQ-015 SHALL implement the states IDLE, WAIT_PAR and SEND, plus a byte index idx in the range 0..MSG_LEN+PAR_LEN-1 (0..67).
REQ-016 SHALL drive msg_ready = (state==IDLE) | (state==SEND & idx==67 & m_ready), combinationally.
REQ-017 SHALL, when msg_valid & msg_ready, register all of msg_in into the message buffer and enter WAIT_PAR.
REQ-018 SHALL, in WAIT_PAR with parity_valid high, register parity_in and enter SEND with idx=0; WAIT_PAR has no timeout.
REQ-019 SHALL ignore parity_valid in IDLE and in SEND; the stored parity is left unchanged.
REQ-020 SHALL hold m_valid high exactly while in SEND.
REQ-021 SHALL set m_data to msg_buf[idx] for idx 0..63 and to par_buf[idx-64] for idx 64..67, so that msg_in[0] is sent first.
REQ-022 SHALL drive m_last = 1 only when in SEND with idx==67.
REQ-023 SHALL increment idx when m_valid & m_ready, and SHALL hold m_data, m_last and idx stable while m_valid & !m_ready.
REQ-024 SHALL, on a handshake at idx==67, enter WAIT_PAR if a new message is accepted in that same cycle, otherwise IDLE.
REQ-025 SHALL meet the latency: message accepted at cycle T, parity at T+1, first byte presented with m_valid at T+2.
REQ-026 SHALL sustain a throughput of one codeword per 69 cycles with m_ready held high.
REQ-027 SHALL count a message as dropped when msg_valid & !msg_ready; drop_cnt saturates at 0xFFFF and never wraps.
REQ-028 SHALL leave the buffers untouched when a message is dropped; the codeword in flight is not corrupted.

Reset
REQ-029 SHALL, on rst asserted, immediately set state=IDLE, idx=0, m_valid=0, m_last=0, m_data=0 and drop_cnt=0.
REQ-030 SHALL abort any codeword in flight on reset mid-SEND or mid-WAIT_PAR, with no resume after rst deasserts.
REQ-031 SHALL have msg_ready=1 on the first clock edge after rst deasserts; buffer contents need not be reset.

Configuration
REQ-032 SHALL compile the drop counter logic of REQ-027 only when macro RS_SERIALIZER_DROP_CNT_EN is defined.
REQ-033 SHALL, without RS_SERIALIZER_DROP_CNT_EN, tie drop_cnt to 0 with no counter logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover: msg_in[i]=i, parity_valid at T+1 with parity {0xA1,0xB2,0xC3,0xD4}, m_ready=1 -> bytes 0x00..0x3F then A1,B2,C3,D4 at T+2..T+69; m_last only on D4.
REQ-035 SHALL cover: m_ready toggling 1/0 every cycle -> same 68-byte sequence, no byte duplicated or skipped, m_data stable while stalled.
REQ-036 SHALL cover: back-to-back messages, second msg_valid on the idx==67 handshake cycle -> accepted; second codeword's first byte 2 cycles later; drop_cnt=0.
REQ-037 SHALL cover: msg_valid pulse at idx==10 of SEND -> first codeword intact; drop_cnt=1 (0 without the macro).
REQ-038 SHALL cover: rst pulse at idx==30 -> m_valid=0 asynchronously; after release msg_ready=1; a new message serializes correctly from byte 0.
REQ-039 SHALL cover: 70000 dropped messages with the macro defined -> drop_cnt=0xFFFF.

Source files
------------

// File: rtl/rs_codeword_serializer.sv
// -----------------------------------------------------------------------------
// rs_codeword_serializer
//
// Takes one Reed-Solomon message as a parallel word, waits for the encoder's
// parity bytes (which arrive on the cycle after the message), then streams
// the codeword out one byte per handshake: message bytes msg_in[0] first,
// followed by the parity bytes. A new message can be accepted on the
// handshake of the final byte, which gives back-to-back codewords.
//
// Optional feature macro: RS_SERIALIZER_DROP_CNT_EN
//   defined   -> drop_cnt counts messages offered while msg_ready is low,
//                saturating at 0xFFFF.
//   undefined -> drop_cnt is tied to zero and no counter is built.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   msg_in        in   MSG_LEN message bytes, sampled when msg_valid & msg_ready
//   msg_valid     in   a message is offered this cycle
//   msg_ready     out  the block accepts msg_in this cycle (combinational)
//   parity_in     in   PAR_LEN parity bytes from the encoder
//   parity_valid  in   parity_in is valid (only honoured while waiting for it)
//   m_data        out  serial codeword byte
//   m_valid       out  m_data is valid
//   m_ready       in   downstream accepts m_data
//   m_last        out  current byte is the final codeword byte
//   drop_cnt      out  number of messages dropped
// -----------------------------------------------------------------------------
module rs_codeword_serializer #(
    parameter int MSG_LEN = 64,
    parameter int PAR_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MSG_LEN-1:0][7:0] msg_in,
    input  logic                    msg_valid,
    output logic                    msg_ready,
    input  logic [PAR_LEN-1:0][7:0] parity_in,
    input  logic                    parity_valid,
    output logic [7:0]              m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [15:0]             drop_cnt
);

    localparam int CW_LEN = MSG_LEN + PAR_LEN;
    localparam int IDX_W  = $clog2(CW_LEN + 1);
    localparam int MSG_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int PAR_W  = (PAR_LEN > 1) ? $clog2(PAR_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CW_LEN - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PAR = 2'd1,
        SEND     = 2'd2
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [MSG_LEN-1:0][7:0] r_msg_buf;
    logic [PAR_LEN-1:0][7:0] r_par_buf;
    logic [7:0]              r_m_data;
    logic                    r_m_valid;
    logic                    r_m_last;

    logic                    w_msg_accept;
    logic [IDX_W-1:0]        w_next_idx;
    logic [7:0]              w_next_byte;

    assign msg_ready    = (r_state == IDLE) ||
                          ((r_state == SEND) && (r_idx == LAST_IDX) && m_ready);
    assign w_msg_accept = msg_valid && msg_ready;
    assign w_next_idx   = r_idx + IDX_W'(1);

    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;

    // Byte that becomes visible after the current one is accepted. m_data is
    // registered, so it is selected one index ahead.
    always_comb begin
        w_next_byte = 8'h00;
        if (w_next_idx < IDX_W'(MSG_LEN))
            w_next_byte = r_msg_buf[MSG_W'(w_next_idx)];
        else
            w_next_byte = r_par_buf[PAR_W'(w_next_idx - IDX_W'(MSG_LEN))];
    end

    // NOTE: the codeword buffers carry no reset; they are only read after a
    // fresh write, so resetting them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_msg_accept)
            r_msg_buf <= msg_in;
        if ((r_state == WAIT_PAR) && parity_valid)
            r_par_buf <= parity_in;
    end

    // NOTE: every sequential assignment uses <= so all registers update from
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_m_data  <= 8'h00;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_msg_accept)
                        r_state <= WAIT_PAR;
                end
                WAIT_PAR: begin
                    if (parity_valid) begin
                        r_state   <= SEND;
                        r_idx     <= '0;
                        r_m_data  <= r_msg_buf[0];
                        r_m_valid <= 1'b1;
                        r_m_last  <= 1'b0;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        if (r_idx == LAST_IDX) begin
                            // A message taken on the last handshake goes
                            // straight to waiting for its parity.
                            r_state   <= w_msg_accept ? WAIT_PAR : IDLE;
                            r_idx     <= '0;
                            r_m_valid <= 1'b0;
                            r_m_last  <= 1'b0;
                        end else begin
                            r_idx    <= w_next_idx;
                            r_m_data <= w_next_byte;
                            r_m_last <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_idx     <= '0;
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RS_SERIALIZER_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_drop_cnt <= 16'h0000;
        else if (msg_valid && !msg_ready && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule
